dmem_mmio_target: RTL

- Data-side store responder for the single-cycle core. Receives the core's MemWrite/ALUResult/WriteData store stream and returns ReadData.
- Word-addressed data RAM, plus an MMIO region containing:
  - a test-status register (PASS/FAIL state machine),
  - a console byte FIFO with a valid/ready drain port,
  - a store counter.
- Sits beside the core in the top level and replaces the bench-side address/data compare with an in-design pass/fail signature.

---
 rtl/dmem_mmio_target.sv | 116 +++++++++++
 1 files changed

// File: rtl/dmem_mmio_target.sv
// Data-side store responder: word RAM plus MMIO test-status FSM, console byte FIFO
// and store counter, giving the single-cycle core an in-design pass/fail signature.
module dmem_mmio_target #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        test_done,
  output logic        test_pass,
  output logic [31:0] fail_code,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        addr_err,
  output logic        con_ovf,
  output logic [31:0] store_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] RAM_BYTES  = 32'(4 * DEPTH);
  localparam logic [31:0] ADDR_STAT  = 32'h8000_0000;
  localparam logic [31:0] ADDR_CONS  = 32'h8000_0004;
  localparam logic [31:0] ADDR_COUNT = 32'h8000_0008;

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0]   mem     [DEPTH];
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] occ;
  logic [1:0]    state;

  logic          aligned, isRam, isStatus, isConsole, isCount, mapped;
  logic          accept, badStore, push, pop, fifoFull, pushOk;
  logic [AW-1:0] ramIdx;

  assign aligned   = (ALUResult[1:0] == 2'b00);
  assign isRam     = ~ALUResult[31] && (ALUResult < RAM_BYTES);
  assign isStatus  = (ALUResult == ADDR_STAT);
  assign isConsole = (ALUResult == ADDR_CONS);
  assign isCount   = (ALUResult == ADDR_COUNT);
  assign mapped    = aligned & (isRam | isStatus | isConsole | isCount);
  assign ramIdx    = ALUResult[AW+1:2];

  // Gating with rst keeps the unreset storage from taking a store on an edge held in reset.
  assign accept    = rst & MemWrite & mapped;
  assign badStore  = MemWrite & ~mapped;

  assign fifoFull  = (occ == CW'(FIFO_DEPTH));
  assign pop       = con_valid & con_ready;
  assign push      = accept & isConsole;
  assign pushOk    = push & (~fifoFull | pop);

  assign test_done = (state != ST_RUN);
  assign test_pass = (state == ST_PASS);
  assign con_valid = (occ != '0);
  assign con_data  = con_valid ? fifoMem[rdPtr] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      fail_code <= '0;
      store_cnt <= '0;
      addr_err  <= 1'b0;
      con_ovf   <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      occ       <= '0;
    end else begin
      if (badStore) addr_err <= 1'b1;
      if (accept)   store_cnt <= satInc(store_cnt);
      // PASS and FAIL are terminal; STATUS stores after that are counted only.
      if (accept && isStatus && state == ST_RUN) begin
        if (WriteData == 32'd1) begin
          state <= ST_PASS;
        end else if (WriteData != 32'd0) begin
          state     <= ST_FAIL;
          fail_code <= WriteData;
        end
      end
      if (push && fifoFull && !pop) con_ovf <= 1'b1;
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= rdPtr + PW'(1);
      occ <= occ + CW'(pushOk) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && isRam) mem[ramIdx] <= WriteData;
    if (pushOk)          fifoMem[wrPtr] <= WriteData[7:0];
  end

  always_comb begin
    ReadData = '0;
    if (aligned) begin
      if (isRam)          ReadData = mem[ramIdx];
      else if (isStatus)  ReadData = {30'b0, test_pass, test_done};
      else if (isConsole) ReadData = 32'(occ);
      else if (isCount)   ReadData = store_cnt;
    end
  end

endmodule
